// File: rtl/timer_sched_pkg.sv
// Shared encodings for the timer scheduler: command opcodes and channel mode.
package timer_pkg;

  typedef enum logic [1:0] {
    OP_NOP            = 2'b00,
    OP_START_ONESHOT  = 2'b01,
    OP_START_PERIODIC = 2'b10,
    OP_STOP           = 2'b11
  } op_e;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/timer_sched_if.sv
// Command/status bundle between the register front end and the timer scheduler.
interface timer_sched_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CW = $clog2(NCH);

  logic             en;
  logic             cmd_valid;
  logic [CW-1:0]    cmd_ch;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_period;
  logic [NCH-1:0]   irq_clr;
  logic [WIDTH-1:0] now;
  logic [NCH-1:0]   active;
  logic [NCH-1:0]   pending;
  logic             irq;

  modport master (
    output en, cmd_valid, cmd_ch, cmd_op, cmd_period, irq_clr,
    input  now, active, pending, irq
  );

  modport slave (
    input  en, cmd_valid, cmd_ch, cmd_op, cmd_period, irq_clr,
    output now, active, pending, irq
  );
endinterface

// File: rtl/timer_sched_cmp.sv
// Wrap-safe expiry test: a deadline has passed when (now - deadline) is non-negative.
module timer_cmp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] now_i,
  input  logic [WIDTH-1:0] deadline_i,
  input  logic             active_i,
  output logic             expired_o
);
  logic [WIDTH-1:0] diff;

  assign diff      = now_i - deadline_i;
  assign expired_o = active_i & ~diff[WIDTH-1];
endmodule

// File: rtl/timer_sched.sv
// Multi-channel timer scheduler: one time base, one comparator scanned round-robin
// over per-channel deadline/period/mode state.
module timer_sched
  import timer_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  timer_sched_if.slave  bus
);
  localparam int unsigned CW = $clog2(NCH);

  logic [WIDTH-1:0] now_q, now_d;
  logic [CW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] deadline_q [NCH];
  logic [WIDTH-1:0] deadline_d [NCH];
  logic [WIDTH-1:0] period_q   [NCH];
  logic [WIDTH-1:0] period_d   [NCH];
  mode_e            mode_q     [NCH];
  mode_e            mode_d     [NCH];
  logic [NCH-1:0]   active_q, active_d;
  logic [NCH-1:0]   pending_q, pending_d;

  logic [WIDTH-1:0] p_eff;
  logic             expired;
  logic             cmd_hit;
  op_e              op;

  assign op      = op_e'(bus.cmd_op);
  assign cmd_hit = bus.cmd_valid && (op != OP_NOP) && (bus.cmd_ch == ptr_q);

  always_comb begin
    p_eff          = bus.cmd_period;
    p_eff[WIDTH-1] = 1'b0;
    if (p_eff == '0) p_eff = WIDTH'(1);
  end

  timer_cmp #(.WIDTH(WIDTH)) u_cmp (
    .now_i      (now_q),
    .deadline_i (deadline_q[ptr_q]),
    .active_i   (active_q[ptr_q]),
    .expired_o  (expired)
  );

  // Scan result applied first so a command to the scanned channel overrides it.
  always_comb begin
    now_d      = now_q + WIDTH'(bus.en);
    ptr_d      = ptr_q + CW'(1);
    deadline_d = deadline_q;
    period_d   = period_q;
    mode_d     = mode_q;
    active_d   = active_q;
    pending_d  = pending_q & ~bus.irq_clr;

    if (expired && !cmd_hit) begin
      pending_d[ptr_q] = 1'b1;
      if (mode_q[ptr_q] == MODE_PERIODIC)
        deadline_d[ptr_q] = deadline_q[ptr_q] + period_q[ptr_q];
      else
        active_d[ptr_q] = 1'b0;
    end

    if (bus.cmd_valid) begin
      case (op)
        OP_START_ONESHOT, OP_START_PERIODIC: begin
          deadline_d[bus.cmd_ch] = now_q + p_eff;
          period_d[bus.cmd_ch]   = p_eff;
          mode_d[bus.cmd_ch]     = (op == OP_START_PERIODIC) ? MODE_PERIODIC : MODE_ONESHOT;
          active_d[bus.cmd_ch]   = 1'b1;
        end
        OP_STOP: active_d[bus.cmd_ch] = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_q     <= '0;
      ptr_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        deadline_q[i] <= '0;
        period_q[i]   <= '0;
        mode_q[i]     <= MODE_ONESHOT;
      end
    end else begin
      now_q      <= now_d;
      ptr_q      <= ptr_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      deadline_q <= deadline_d;
      period_q   <= period_d;
      mode_q     <= mode_d;
    end
  end

  assign bus.now     = now_q;
  assign bus.active  = active_q;
  assign bus.pending = pending_q;
  assign bus.irq     = |pending_q;
endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: a 32-bit instance for the main scenarios and an
// 8-bit instance for time-base wrap.
module tb_timer_sched;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  timer_sched_if #(.NCH(4), .WIDTH(32)) b32 ();
  timer_sched_if #(.NCH(4), .WIDTH(8))  b8 ();

  timer_sched #(.NCH(4), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b32.slave)
  );

  timer_sched #(.NCH(4), .WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd32(input int ch, input op_e op, input logic [31:0] per);
    b32.cmd_ch     = 2'(ch);
    b32.cmd_op     = op;
    b32.cmd_period = per;
    b32.cmd_valid  = 1'b1;
    step();
    b32.cmd_valid  = 1'b0;
    b32.cmd_op     = OP_NOP;
  endtask

  task automatic cmd8(input int ch, input op_e op, input logic [7:0] per);
    b8.cmd_ch     = 2'(ch);
    b8.cmd_op     = op;
    b8.cmd_period = per;
    b8.cmd_valid  = 1'b1;
    step();
    b8.cmd_valid  = 1'b0;
    b8.cmd_op     = OP_NOP;
  endtask

  task automatic clear32(input logic [3:0] mask);
    b32.irq_clr = mask;
    step();
    b32.irq_clr = '0;
  endtask

  initial begin
    rst = 1'b1;
    b32.en = 1'b1; b32.cmd_valid = 1'b0; b32.cmd_ch = '0; b32.cmd_op = OP_NOP;
    b32.cmd_period = '0; b32.irq_clr = '0;
    b8.en = 1'b1;  b8.cmd_valid = 1'b0;  b8.cmd_ch = '0;  b8.cmd_op = OP_NOP;
    b8.cmd_period = '0;  b8.irq_clr = '0;

    step(2);
    check("rst_now", b32.now, 0);
    check("rst_active", b32.active, 0);
    check("rst_pending", b32.pending, 0);
    check("rst_irq", b32.irq, 0);
    rst = 1'b0;

    // one-shot ch0, p=10 issued at now=5 -> deadline 15, ch0 scanned at now=16
    step(5);
    check("now5", b32.now, 5);
    cmd32(0, OP_START_ONESHOT, 32'd10);
    check("os_active", b32.active, 4'b0001);
    step(10);
    check("os_now16_pend", b32.pending, 0);
    step();
    check("os_now17", b32.now, 17);
    check("os_pend", b32.pending, 4'b0001);
    check("os_active_off", b32.active, 0);
    check("os_irq", b32.irq, 1);
    clear32(4'b0001);
    check("os_clr_pend", b32.pending, 0);
    check("os_clr_irq", b32.irq, 0);

    // periodic ch1, p=9 at now=18 -> deadline 27, fires at 29; next deadline 36 fires at 37
    cmd32(1, OP_START_PERIODIC, 32'd9);
    check("per_active", b32.active, 4'b0010);
    step(10);
    check("per_now29_pend", b32.pending, 0);
    step();
    check("per_first", b32.pending, 4'b0010);
    clear32(4'b0010);
    check("per_clr", b32.pending, 0);
    step(6);
    check("per_now37_pend", b32.pending, 0);
    b32.irq_clr = 4'b0010;
    step();
    b32.irq_clr = '0;
    check("per_second_setwins", b32.pending, 4'b0010);
    check("per_still_active", b32.active, 4'b0010);
    cmd32(1, OP_STOP, 32'd0);
    check("stop_active", b32.active, 0);
    check("stop_keeps_pend", b32.pending, 4'b0010);
    clear32(4'b0010);

    // ch3 one-shot p=4 at now=40 -> expires on scan at now=47, stop issued that cycle
    cmd32(3, OP_START_ONESHOT, 32'd4);
    check("col_active", b32.active, 4'b1000);
    step(6);
    cmd32(3, OP_STOP, 32'd0);
    check("col_pend", b32.pending, 0);
    check("col_active_off", b32.active, 0);
    step(4);
    check("col_later_pend", b32.pending, 0);
    check("now52", b32.now, 52);

    // period 0 behaves as 1: issued at 52 -> deadline 53, ch1 scanned at 53
    cmd32(1, OP_START_ONESHOT, 32'd0);
    check("p0_active", b32.active, 4'b0010);
    check("p0_pend_early", b32.pending, 0);
    step();
    check("p0_pend", b32.pending, 4'b0010);
    clear32(4'b0010);

    // MSB ignored: 0x8000_0005 at now=55 -> deadline 60, ch2 scans at 58 (no) and 62
    cmd32(2, OP_START_ONESHOT, 32'h8000_0005);
    step(6);
    check("msb_now62_pend", b32.pending, 0);
    step();
    check("msb_pend", b32.pending, 4'b0100);
    clear32(4'b0100);

    // en=0 freezes time base: ch0 deadline 66 armed at now=64
    cmd32(0, OP_START_ONESHOT, 32'd2);
    b32.en = 1'b0;
    step(100);
    check("en0_now", b32.now, 65);
    check("en0_pend", b32.pending, 0);
    check("en0_active", b32.active, 4'b0001);
    b32.en = 1'b1;
    step(3);
    check("en1_now68_pend", b32.pending, 0);
    step();
    check("en1_pend", b32.pending, 4'b0001);

    // async reset mid-countdown
    cmd32(1, OP_START_PERIODIC, 32'd20);
    check("pre_rst_active", b32.active, 4'b0010);
    step(2);
    #2 rst = 1'b1;
    #1;
    check("arst_now", b32.now, 0);
    check("arst_active", b32.active, 0);
    check("arst_pending", b32.pending, 0);
    check("arst_irq", b32.irq, 0);
    step(2);
    rst = 1'b0;
    step(100);
    check("post_rst_now", b32.now, 100);
    check("post_rst_pend", b32.pending, 0);
    check("post_rst_active", b32.active, 0);

    // 8-bit wrap: p=10 at now=250 -> deadline 4, ch2 scanned at 254, 2 (no) and 6 (yes)
    step(150);
    check("w8_now250", b8.now, 250);
    cmd8(2, OP_START_ONESHOT, 8'd10);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("w8_nofire_%0d", (251 + i) % 256), b8.pending, 0);
      step();
    end
    check("w8_now6", b8.now, 6);
    step();
    check("w8_fire", b8.pending, 4'b0100);
    check("w8_active_off", b8.active, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/timer_sched.md
# timer_sched

Multi-channel timer scheduler that shares one free-running time base and one expiry comparator among NCH software timer channels. Each channel is started in one-shot or periodic mode with its own period and raises a per-channel pending flag on expiry. The block sits between the CPU register interface and the interrupt controller and replaces per-channel counter instances when many timers are needed.

## Interface
- NCH, 4: number of channels, power of two, 2..16
- WIDTH, 32: width of time base, periods and deadlines
- CW, $clog2(NCH): channel index width
---
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  time base advance enable
- cmd_valid  in  1  command strobe, always accepted in the same cycle
- cmd_ch  in  CW  target channel
- cmd_op  in  2  00 nop, 01 start one-shot, 10 start periodic, 11 stop
- cmd_period  in  WIDTH  period in clk ticks
- irq_clr  in  NCH  per-channel pending clear, one bit per channel
- now  out  WIDTH  time base value
- active  out  NCH  channel armed
- pending  out  NCH  channel expired, not yet cleared
- irq  out  1  OR of pending

## Operation
- Time base: `now` increments by 1 on each clk edge with en=1 and wraps modulo 2^WIDTH. It holds when en=0.
- Effective period: `p = cmd_period` with the MSB forced to 0. If the result is 0, p is treated as 1.
- Start command (op 01/10):
  - deadline[ch] <= now + p, period[ch] <= p, mode[ch] <= periodic?1:0, active[ch] <= 1.
  - pending is untouched.
  - Re-starting an active channel re-arms it from the current now.
- Stop command (op 11): active[ch] <= 0. Pending is untouched.
- Scan pointer:
  - ptr cycles 0..NCH-1, advancing every clk regardless of en.
  - Each cycle, the single comparator examines channel ptr.
- Expiry test: the channel is active and the MSB of (now - deadline[ptr]) is 0. This comparison is wrap-safe for p < 2^(WIDTH-1).
- On expiry:
  - pending[ptr] <= 1.
  - One-shot: active[ptr] <= 0.
  - Periodic: deadline[ptr] <= deadline[ptr] + period[ptr], which gives a drift-free cadence. If the channel lags by more than one period, it re-expires on its next scan.
- Simultaneous events:
  - A command to channel ptr in the same cycle wins over the scan result, and the scan result is discarded.
  - A pending set and an irq_clr on the same bit in the same cycle: set wins.
- Reset, asynchronous and mid-operation: now, ptr, active, pending, deadline, period and mode all go to 0. The outputs are now=0, active=0, pending=0, irq=0.

## Timing
- Command effects are visible on active/deadline on the clk edge after cmd_valid.
- Expiry detection latency:
  - pending rises on the edge that ends the scan cycle in which now ≥ deadline.
  - This is within NCH cycles after now reaches the deadline, provided en stays high.
- irq is combinational OR of the registered pending bits. It carries no extra register stage.
- irq_clr takes effect on the next edge.
- Each channel is examined once every NCH cycles. Periods shorter than NCH still fire, but only once per scan.

## Structure
- Package timer_pkg holds:
  - the cmd_op encodings: OP_NOP, OP_START_ONESHOT, OP_START_PERIODIC, OP_STOP
  - the mode encoding
- Sub-module timer_cmp: the combinational wrap-safe expiry comparator, inputs now, deadline and active, output expired. It is instantiated once and shared via the ptr mux.
- Per-channel state lives in register arrays inside timer_sched: deadline, period, mode, active, pending.

## Test plan
- One-shot, NCH=4, WIDTH=32, en=1: start ch0 with p=10 at now=5 -> pending[0] rises between now=15 and now=19; active[0] falls at the same edge; irq=1 until irq_clr[0].
- Periodic: start ch1 with p=8 at now=0 -> pending[1] is set after now≥8; after clearing, it is set again after now≥16 and now≥24; deadline shows no drift.
- Wrap with WIDTH=8: run until now=250, then start ch2 with p=10 -> expiry fires after now wraps to 4..7. There is no early fire at now=250..255.
- Collisions:
  - A stop to ch3 issued in the cycle ch3 is scanned and expired -> pending[3] stays 0 and active[3]=0.
  - irq_clr on a bit in the cycle it sets -> the bit stays 1.
- Period edge cases: cmd_period=0 -> behaves as p=1. cmd_period=0x8000_0005 -> behaves as p=5.
- en and reset: with en=0, now and pending are frozen for 100 cycles. Asserting rst mid-countdown drives all outputs to 0 immediately, and nothing fires after release.
